// File: rtl/regfile_wb_arbiter_if.sv
// Write-back request bundle shared by requesters A and B.
// The master side drives valid/addr/data, and the arbiter (slave side) returns ready.
interface regfile_wb_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  a_valid;
  logic                  a_ready;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_data;
  logic                  b_valid;
  logic                  b_ready;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_data;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter that shares the register file write port between two write-back requesters.
// It has a registered write stage, one-cycle read bypass and a saturating conflict counter.
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_wb_arbiter_if.slave   req,
  output logic                  WE3,
  output logic [ADDR_WIDTH-1:0] AD3,
  output logic [DATA_WIDTH-1:0] WD3,
  input  logic [ADDR_WIDTH-1:0] AD1,
  input  logic [ADDR_WIDTH-1:0] AD2,
  input  logic [DATA_WIDTH-1:0] RD1_rf,
  input  logic [DATA_WIDTH-1:0] RD2_rf,
  output logic [DATA_WIDTH-1:0] RD1,
  output logic [DATA_WIDTH-1:0] RD2,
  output logic                  rr_ptr,
  output logic [CNT_WIDTH-1:0]  conflict_cnt
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] ad_q, ad_d;
  logic [DATA_WIDTH-1:0] wd_q, wd_d;
  logic                  rr_q, rr_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  a_ready_s, b_ready_s;
  logic                  a_fire_s, b_fire_s, both_valid_s;

  // The write-stage entry is forwarded only when it commits and targets a non-zero register.
  function automatic logic [DATA_WIDTH-1:0] bypass_sel(
    input logic                  we,
    input logic [ADDR_WIDTH-1:0] wr_addr,
    input logic [ADDR_WIDTH-1:0] rd_addr,
    input logic [DATA_WIDTH-1:0] wr_data,
    input logic [DATA_WIDTH-1:0] rf_data
  );
    if (we && (wr_addr == rd_addr) && (rd_addr != ADDR_ZERO)) begin
      return wr_data;
    end else begin
      return rf_data;
    end
  endfunction

  // Each ready depends only on the other port's valid, which prevents a valid-to-ready loop.
  always_comb begin
    a_ready_s    = !req.b_valid || !rr_q;
    b_ready_s    = !req.a_valid || rr_q;
    a_fire_s     = req.a_valid && a_ready_s;
    b_fire_s     = req.b_valid && b_ready_s;
    both_valid_s = req.a_valid && req.b_valid;
  end

  assign req.a_ready = a_ready_s;
  assign req.b_ready = b_ready_s;

  // Next state of the write stage, the priority pointer and the conflict counter.
  always_comb begin
    we_d  = 1'b0;
    ad_d  = ad_q;
    wd_d  = wd_q;
    rr_d  = rr_q;
    cnt_d = cnt_q;
    if (a_fire_s) begin
      we_d = (req.a_addr != ADDR_ZERO);
      ad_d = req.a_addr;
      wd_d = req.a_data;
      rr_d = 1'b1;
    end else if (b_fire_s) begin
      we_d = (req.b_addr != ADDR_ZERO);
      ad_d = req.b_addr;
      wd_d = req.b_data;
      rr_d = 1'b0;
    end else begin
      we_d = 1'b0;
    end
    if (both_valid_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers; reset discards any write still held in the output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q  <= 1'b0;
      ad_q  <= ADDR_ZERO;
      wd_q  <= {DATA_WIDTH{1'b0}};
      rr_q  <= 1'b0;
      cnt_q <= {CNT_WIDTH{1'b0}};
    end else begin
      we_q  <= we_d;
      ad_q  <= ad_d;
      wd_q  <= wd_d;
      rr_q  <= rr_d;
      cnt_q <= cnt_d;
    end
  end

  assign WE3          = we_q;
  assign AD3          = ad_q;
  assign WD3          = wd_q;
  assign rr_ptr       = rr_q;
  assign conflict_cnt = cnt_q;

  // The read bypass covers only the cycle in which the register file has not yet captured the write.
  always_comb begin
    RD1 = bypass_sel(we_q, ad_q, AD1, wd_q, RD1_rf);
    RD2 = bypass_sel(we_q, ad_q, AD2, wd_q, RD2_rf);
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter, built with a 4-bit conflict counter
// so that the counter can be driven into saturation.
module tb_regfile_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          WE3;
  logic [AW-1:0] AD3, AD1, AD2;
  logic [DW-1:0] WD3, RD1_rf, RD2_rf, RD1, RD2;
  logic          rr_ptr;
  logic [CW-1:0] conflict_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  regfile_wb_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  regfile_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .req(bus),
    .WE3(WE3), .AD3(AD3), .WD3(WD3),
    .AD1(AD1), .AD2(AD2), .RD1_rf(RD1_rf), .RD2_rf(RD2_rf),
    .RD1(RD1), .RD2(RD2), .rr_ptr(rr_ptr), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    bus.a_valid = v; bus.a_addr = ad; bus.a_data = d;
  endtask

  task automatic drive_b(input logic v, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    bus.b_valid = v; bus.b_addr = ad; bus.b_data = d;
  endtask

  initial begin
    drive_a(1'b0, 5'd0, 32'h0);
    drive_b(1'b0, 5'd0, 32'h0);
    AD1 = 5'd0; AD2 = 5'd0; RD1_rf = 32'h0; RD2_rf = 32'h0;
    tick(); tick();
    check("rst_we3", {31'b0, WE3}, 32'h0);
    check("rst_ad3", {27'b0, AD3}, 32'h0);
    check("rst_wd3", WD3, 32'h0);
    check("rst_rr", {31'b0, rr_ptr}, 32'h0);
    check("rst_cnt", {28'b0, conflict_cnt}, 32'h0);
    check("idle_a_ready", {31'b0, bus.a_ready}, 32'h1);
    check("idle_b_ready", {31'b0, bus.b_ready}, 32'h1);
    rst = 1'b0;

    // Four consecutive A writes: x1..x4 = 0x11..0x44
    for (int i = 1; i <= 4; i++) begin
      drive_a(1'b1, 5'(i), 32'(i * 32'h11));
      #1;
      check("seq_a_ready", {31'b0, bus.a_ready}, 32'h1);
      tick();
      check("seq_we3", {31'b0, WE3}, 32'h1);
      check("seq_ad3", {27'b0, AD3}, 32'(i));
      check("seq_wd3", WD3, 32'(i * 32'h11));
      check("seq_rr", {31'b0, rr_ptr}, 32'h1);
    end
    drive_a(1'b0, 5'd0, 32'h0);
    tick();
    check("seq_idle_we3", {31'b0, WE3}, 32'h0);
    check("seq_hold_ad3", {27'b0, AD3}, 32'd4);
    check("seq_hold_wd3", WD3, 32'h44);

    // A lone B write moves the pointer back to A
    drive_b(1'b1, 5'd5, 32'h55);
    tick();
    check("b_only_ad3", {27'b0, AD3}, 32'd5);
    check("b_only_rr", {31'b0, rr_ptr}, 32'h0);
    check("b_only_cnt", {28'b0, conflict_cnt}, 32'h0);

    // Both requesters valid for four cycles, starting with rr_ptr=0
    drive_a(1'b1, 5'd8, 32'hA0);
    drive_b(1'b1, 5'd9, 32'hB0);
    #1;
    check("cf1_a_ready", {31'b0, bus.a_ready}, 32'h1);
    check("cf1_b_ready", {31'b0, bus.b_ready}, 32'h0);
    tick();
    check("cf1_ad3", {27'b0, AD3}, 32'd8);
    check("cf1_wd3", WD3, 32'hA0);
    check("cf1_rr", {31'b0, rr_ptr}, 32'h1);
    drive_a(1'b1, 5'd10, 32'hA1);
    #1;
    check("cf2_a_ready", {31'b0, bus.a_ready}, 32'h0);
    check("cf2_b_ready", {31'b0, bus.b_ready}, 32'h1);
    tick();
    check("cf2_ad3", {27'b0, AD3}, 32'd9);
    check("cf2_wd3", WD3, 32'hB0);
    check("cf2_rr", {31'b0, rr_ptr}, 32'h0);
    drive_b(1'b1, 5'd11, 32'hB1);
    #1;
    check("cf3_a_ready", {31'b0, bus.a_ready}, 32'h1);
    tick();
    check("cf3_ad3", {27'b0, AD3}, 32'd10);
    check("cf3_wd3", WD3, 32'hA1);
    drive_a(1'b1, 5'd12, 32'hA2);
    #1;
    check("cf4_b_ready", {31'b0, bus.b_ready}, 32'h1);
    tick();
    check("cf4_ad3", {27'b0, AD3}, 32'd11);
    check("cf4_wd3", WD3, 32'hB1);
    check("cf4_we3", {31'b0, WE3}, 32'h1);
    check("cf_cnt", {28'b0, conflict_cnt}, 32'd4);
    drive_a(1'b0, 5'd0, 32'h0);
    drive_b(1'b0, 5'd0, 32'h0);

    // x0 write from B: the handshake completes but nothing is written or bypassed
    drive_b(1'b1, 5'd0, 32'hDEADBEEF);
    #1;
    check("x0_b_ready", {31'b0, bus.b_ready}, 32'h1);
    tick();
    drive_b(1'b0, 5'd0, 32'h0);
    AD1 = 5'd0; RD1_rf = 32'h55;
    #1;
    check("x0_we3", {31'b0, WE3}, 32'h0);
    check("x0_ad3", {27'b0, AD3}, 32'd0);
    check("x0_wd3", WD3, 32'hDEADBEEF);
    check("x0_rd1", RD1, 32'h55);
    check("x0_rr", {31'b0, rr_ptr}, 32'h0);

    // Bypass on RD1: x7 = 0x12345678
    drive_a(1'b1, 5'd7, 32'h12345678);
    tick();
    drive_a(1'b0, 5'd0, 32'h0);
    AD1 = 5'd7; RD1_rf = 32'h0; AD2 = 5'd3; RD2_rf = 32'hABC;
    #1;
    check("byp1_rd1", RD1, 32'h12345678);
    check("byp1_rd2_nomatch", RD2, 32'hABC);
    tick();
    RD1_rf = 32'hCAFE;
    #1;
    check("byp1_rd1_n2", RD1, 32'hCAFE);

    // Bypass on RD2: x9 = 0x99990001
    drive_a(1'b1, 5'd9, 32'h99990001);
    tick();
    drive_a(1'b0, 5'd0, 32'h0);
    AD2 = 5'd9; RD2_rf = 32'h0; AD1 = 5'd8; RD1_rf = 32'h77;
    #1;
    check("byp2_rd2", RD2, 32'h99990001);
    check("byp2_rd1_nomatch", RD1, 32'h77);
    tick();
    RD2_rf = 32'hBEEF;
    #1;
    check("byp2_rd2_n2", RD2, 32'hBEEF);

    // Reset asserted mid-stream while WE3=1 takes effect before the next edge
    drive_a(1'b1, 5'd3, 32'h33);
    tick();
    drive_a(1'b0, 5'd0, 32'h0);
    check("pre_rst_we3", {31'b0, WE3}, 32'h1);
    check("pre_rst_cnt", {28'b0, conflict_cnt}, 32'd4);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_we3", {31'b0, WE3}, 32'h0);
    check("mid_rst_ad3", {27'b0, AD3}, 32'h0);
    check("mid_rst_wd3", WD3, 32'h0);
    check("mid_rst_rr", {31'b0, rr_ptr}, 32'h0);
    check("mid_rst_cnt", {28'b0, conflict_cnt}, 32'h0);
    tick();
    rst = 1'b0;

    // After release A is preferred; then hold both valid into counter saturation
    drive_a(1'b1, 5'd6, 32'h66);
    drive_b(1'b1, 5'd12, 32'hCC);
    #1;
    check("rel_a_ready", {31'b0, bus.a_ready}, 32'h1);
    check("rel_b_ready", {31'b0, bus.b_ready}, 32'h0);
    tick();
    check("rel_ad3", {27'b0, AD3}, 32'd6);
    check("rel_rr", {31'b0, rr_ptr}, 32'h1);
    check("rel_cnt", {28'b0, conflict_cnt}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("sat_cnt", {28'b0, conflict_cnt}, (i + 2 > 15) ? 32'd15 : 32'(i + 2));
    end
    drive_a(1'b0, 5'd0, 32'h0);
    drive_b(1'b0, 5'd0, 32'h0);
    tick();
    check("sat_final_cnt", {28'b0, conflict_cnt}, 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
